// File: rtl/latch_stim_pkg.sv
// Shared types for the SR storage-element sequencer: FSM states, behavioural model states
// and the {q,qb} patterns each model state should produce.
package latch_stim_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, GATE, HOLD, CHECK, DONE} state_t;
    typedef enum logic [1:0] {Q0, Q1, BOTH0, UNKNOWN} exp_t;

    localparam logic [1:0] PAT_Q1 = 2'b10;
    localparam logic [1:0] PAT_Q0 = 2'b01;
    localparam logic [1:0] PAT_B0 = 2'b00;

    // UNKNOWN has no defined pattern; callers must qualify on it.
    function automatic logic [1:0] exp_pat(input exp_t e);
        case (e)
            Q1:      return PAT_Q1;
            Q0:      return PAT_Q0;
            default: return PAT_B0;
        endcase
    endfunction

    // Releasing s=r=1 to s=r=0 is a race whose winner cannot be predicted.
    function automatic exp_t exp_next(input exp_t cur, input logic [1:0] sr);
        case (sr)
            2'b10:   return Q1;
            2'b01:   return Q0;
            2'b11:   return BOTH0;
            default: return (cur == BOTH0) ? UNKNOWN : cur;
        endcase
    endfunction

endpackage

// File: rtl/latch_stim_seq_sync2.sv
// Two-flop synchronizer for one asynchronous cell output.
// Two cycles of latency, no flow control.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/latch_stim_seq.sv
// Plays stored {s,r} vectors through setup/gate/hold windows on an SR cell and scores the
// synchronized response; SETUP_CYC+GATE_CYC+HOLD_CYC+1 cycles per vector, loads ignored while busy.
module latch_stim_seq
    import latch_stim_pkg::*;
#(
    parameter int DEPTH     = 26,
    parameter int AW        = 5,
    parameter int SETUP_CYC = 4,
    parameter int GATE_CYC  = 8,
    parameter int HOLD_CYC  = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_data,
    input  logic [AW-1:0] n_vec,
    input  logic          start,
    output logic          s,
    output logic          r,
    output logic          g,
    input  logic          q_in,
    input  logic          qb_in,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] vec_idx,
    output logic [7:0]    err_cnt,
    output logic [7:0]    nc_cnt,
    output logic [3:0]    last_lat
);

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] GATE_LAST  = 8'(GATE_CYC - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_CYC - 1);
    localparam logic [3:0] LAT_MAX    = 4'(TIMEOUT);
    localparam logic [3:0] LAT_MAX_M1 = 4'(TIMEOUT - 1);

    logic [1:0]    mem [DEPTH];
    state_t        state, state_nxt;
    exp_t          exp_st, exp_gate;
    logic [7:0]    ph_cnt;
    logic [AW-1:0] n_lat;
    logic [3:0]    lat;
    logic          lat_done;
    logic          qs, qbs;
    logic [1:0]    obs, cur_vec;

    sync2 u_sync_q  (.clk(clk), .reset(reset), .d(q_in),  .q(qs));
    sync2 u_sync_qb (.clk(clk), .reset(reset), .d(qb_in), .q(qbs));

    assign obs      = {qs, qbs};
    assign cur_vec  = mem[vec_idx];
    assign exp_gate = exp_next(exp_st, cur_vec);

    // A load in the same cycle as start lands before vector 0 is read out.
    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE && 32'(wr_addr) < DEPTH)
            mem[wr_addr] <= wr_data;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (n_vec == '0) ? DONE : SETUP;
            SETUP:   if (ph_cnt == SETUP_LAST) state_nxt = GATE;
            GATE:    if (ph_cnt == GATE_LAST) state_nxt = HOLD;
            HOLD:    if (ph_cnt == HOLD_LAST) state_nxt = CHECK;
            CHECK:   state_nxt = (vec_idx == n_lat - 1'b1) ? DONE : SETUP;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s    = 1'b0;
        r    = 1'b0;
        g    = (state == GATE);
        busy = (state != IDLE);
        done = (state == DONE);
        if (state == SETUP || state == GATE || state == HOLD || state == CHECK) begin
            s = cur_vec[1];
            r = cur_vec[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ph_cnt   <= 8'd0;
            vec_idx  <= '0;
            n_lat    <= '0;
            err_cnt  <= 8'd0;
            nc_cnt   <= 8'd0;
            last_lat <= 4'd0;
            lat      <= 4'd0;
            lat_done <= 1'b0;
            exp_st   <= UNKNOWN;
        end else begin
            state  <= state_nxt;
            ph_cnt <= (state_nxt != state) ? 8'd0 : ph_cnt + 8'd1;
            case (state)
                IDLE: if (start) begin
                    n_lat   <= (32'(n_vec) > DEPTH) ? AW'(DEPTH) : n_vec;
                    vec_idx <= '0;
                    err_cnt <= 8'd0;
                    nc_cnt  <= 8'd0;
                end
                SETUP: if (state_nxt == GATE) begin
                    exp_st   <= exp_gate;
                    lat      <= 4'd0;
                    lat_done <= (exp_gate == UNKNOWN);
                end
                // No response by the end of the gate window reads as a timeout.
                GATE: if (!lat_done) begin
                    if (obs == exp_pat(exp_st))
                        lat_done <= 1'b1;
                    else if (state_nxt == HOLD || lat >= LAT_MAX_M1)
                        lat <= LAT_MAX;
                    else
                        lat <= lat + 4'd1;
                end
                CHECK: begin
                    last_lat <= lat;
                    if (exp_st != UNKNOWN && obs != exp_pat(exp_st) && err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                    if (qs == qbs && exp_st != BOTH0 && nc_cnt != 8'hFF)
                        nc_cnt <= nc_cnt + 8'd1;
                    if (state_nxt == SETUP)
                        vec_idx <= vec_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_stim_seq.sv
// Directed bench: drives a simple SR cell model (ideal, stuck, unresponsive) behind the sequencer.
module tb_latch_stim_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic [4:0] n_vec = '0;
    logic       start = 1'b0;
    logic       s, r, g, q_in, qb_in, busy, done;
    logic [4:0] vec_idx;
    logic [7:0] err_cnt, nc_cnt;
    logic [3:0] last_lat;

    int n_chk = 0;
    int n_pass = 0;

    // Cell model: 0 = ideal gated latch (1-cycle response), 1 = q stuck at 0, 2 = q=qb=1 always.
    int   mode = 0;
    logic q_c = 1'b0;
    logic qb_c = 1'b1;

    int   lat_obs[8];
    int   err_obs[8];
    int   dl;
    logic [1:0] sr0;
    logic g_seen;

    always #5 clk = ~clk;

    latch_stim_seq dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .n_vec(n_vec), .start(start), .s(s), .r(r), .g(g), .q_in(q_in), .qb_in(qb_in),
        .busy(busy), .done(done), .vec_idx(vec_idx), .err_cnt(err_cnt), .nc_cnt(nc_cnt),
        .last_lat(last_lat)
    );

    // Ideal latch: a s=r=1 release resolves to q=1.
    always @(posedge clk) begin
        if (mode == 0 && g) begin
            if (s && !r)          begin q_c <= 1'b1; qb_c <= 1'b0; end
            else if (!s && r)     begin q_c <= 1'b0; qb_c <= 1'b1; end
            else if (s && r)      begin q_c <= 1'b0; qb_c <= 1'b0; end
            else if (!q_c && !qb_c) begin q_c <= 1'b1; qb_c <= 1'b0; end
        end
    end

    assign q_in  = (mode == 0) ? q_c  : (mode == 2);
    assign qb_in = (mode == 0) ? qb_c : 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        else
            n_pass++;
    endtask

    task automatic load(input logic [4:0] a, input logic [1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Starts a run at the current negedge; i counts rising edges after the one sampling start.
    // At poke, a start and a load are attempted mid-run; both must be ignored.
    task automatic run_seq(input logic [4:0] n, input int poke);
        g_seen = 1'b0;
        dl = -1;
        sr0 = 2'b00;
        for (int k = 0; k < 8; k++) begin lat_obs[k] = -1; err_obs[k] = -1; end
        n_vec = n;
        start = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin start = 1'b0; wr_en = 1'b0; sr0 = {s, r}; end
            if (i == poke) begin
                start = 1'b1; n_vec = 5'd1;
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 2'b11;
            end
            if (i == poke + 1) begin start = 1'b0; wr_en = 1'b0; n_vec = n; end
            if (g) g_seen = 1'b1;
            if (i >= 17 && i % 17 == 0 && i / 17 <= 8) begin
                lat_obs[i/17-1] = 32'(last_lat);
                err_obs[i/17-1] = 32'(err_cnt);
            end
            if (done) begin dl = i; break; end
        end
        @(negedge clk);
        check("done_one_cycle", 32'(done), 0);
        check("idle_after_done", 32'(busy), 0);
    endtask

    initial begin
        logic found;
        int   dseen;

        repeat (3) @(negedge clk);
        check("rst_s_r_g_busy_done", 32'({s, r, g, busy, done}), 0);
        check("rst_vec_idx", 32'(vec_idx), 0);
        check("rst_err", 32'(err_cnt), 0);
        check("rst_nc", 32'(nc_cnt), 0);
        check("rst_last_lat", 32'(last_lat), 0);
        reset = 1'b0;
        @(negedge clk);

        // Ideal cell, 10,00,01,00; slot 0 written in the start cycle; mid-run start/load poke.
        load(5'd1, 2'b00);
        load(5'd2, 2'b01);
        load(5'd3, 2'b00);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 2'b10;
        run_seq(5'd4, 30);
        check("ideal_first_sr", 32'(sr0), 32'(2'b10));
        check("ideal_done_cycles", dl, 68);
        check("ideal_lat_v0", lat_obs[0], 3);
        check("ideal_lat_v1", lat_obs[1], 0);
        check("ideal_lat_v2", lat_obs[2], 3);
        check("ideal_lat_v3", lat_obs[3], 0);
        check("ideal_err", 32'(err_cnt), 0);
        check("ideal_nc", 32'(nc_cnt), 0);
        check("ideal_vec_idx_kept", 32'(vec_idx), 3);

        // q stuck at 0: vectors 0 and 1 expect Q1.
        mode = 1;
        run_seq(5'd4, -1);
        check("stuck_done_cycles", dl, 68);
        check("stuck_err_after_v0", err_obs[0], 1);
        check("stuck_err", 32'(err_cnt), 2);
        check("stuck_nc", 32'(nc_cnt), 0);

        // 11 then 00: BOTH0 then UNKNOWN.
        mode = 0;
        load(5'd0, 2'b11);
        load(5'd1, 2'b00);
        run_seq(5'd2, -1);
        check("race_done_cycles", dl, 34);
        check("race_lat_v0", lat_obs[0], 3);
        check("race_err_v0", err_obs[0], 0);
        check("race_lat_v1", lat_obs[1], 0);
        check("race_err", 32'(err_cnt), 0);
        check("race_nc", 32'(nc_cnt), 0);

        // Cell never responds.
        mode = 2;
        load(5'd0, 2'b10);
        run_seq(5'd1, -1);
        check("timeout_lat", lat_obs[0], 15);
        check("timeout_err", 32'(err_cnt), 1);
        check("timeout_nc", 32'(nc_cnt), 1);

        // Empty run: counters clear on start, no gate pulse.
        mode = 0;
        run_seq(5'd0, -1);
        check("n0_done_within_2", 32'(dl >= 0 && dl <= 2), 1);
        check("n0_no_gate", 32'(g_seen), 0);
        check("n0_err_cleared", 32'(err_cnt), 0);
        check("n0_nc_cleared", 32'(nc_cnt), 0);

        // Reset during the gate of vector 2.
        mode = 2;
        load(5'd1, 2'b00);
        n_vec = 5'd4;
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (vec_idx == 5'd2 && g) begin found = 1'b1; break; end
        end
        check("abort_reached_gate_v2", 32'(found), 1);
        check("abort_err_before", 32'(err_cnt), 2);
        reset = 1'b1;
        @(negedge clk);
        check("abort_g", 32'(g), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_counters", 32'({err_cnt, nc_cnt}), 0);
        check("abort_vec_idx", 32'(vec_idx), 0);
        check("abort_last_lat", 32'(last_lat), 0);
        reset = 1'b0;
        dseen = 0;
        repeat (5) begin
            @(negedge clk);
            if (done) dseen++;
        end
        check("abort_no_done_pulse", dseen, 0);

        // Restart from vector 0 on the ideal cell; slot 3 must still hold 00.
        mode = 0;
        run_seq(5'd4, -1);
        check("replay_first_sr", 32'(sr0), 32'(2'b10));
        check("replay_done_cycles", dl, 68);
        check("replay_lat_v3", lat_obs[3], 0);
        check("replay_err", 32'(err_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
